csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
- Sequences all writes into the machine-mode CSR file through its single write port and single combinational read port.
- Arbitrates between CSR instructions from execute, trap entry (exception/interrupt) and MRET.
- Trap entry and MRET run multi-cycle: mepc/mcause/mtval/mstatus updates, then a PC redirect to mtvec or mepc.
- Sits between execute/commit and the CSR file; the only block driving the CSR file write port.

Parameters:
- XLEN, 32, datapath width.
- CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343) come from the shared package.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
csr_req_v_i  in  1  CSR instruction valid
csr_op_i  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_adr_i  in  12  CSR address
csr_wdata_i  in  XLEN  rs1 value or zimm
csr_no_wr_i  in  1  rs1==x0 / zimm==0 (suppresses RS/RC write)
csr_ack_o  out  1  CSR instruction completed this cycle
csr_rd_data_o  out  XLEN  old CSR value, for rd
trap_v_i  in  1  trap request
trap_cause_i  in  XLEN  mcause value (bit XLEN-1 = interrupt)
trap_pc_i  in  XLEN  faulting PC
trap_tval_i  in  XLEN  mtval value
mret_v_i  in  1  MRET request
busy_o  out  1  sequence in progress
redirect_v_o  out  1  one-cycle PC redirect
redirect_pc_o  out  XLEN  redirect target
csr_write_v_o  out  1  to CSR file write_v_i
csr_adr_write_o  out  12  to CSR file adr_write_i
csr_wdata_o  out  XLEN  to CSR file data_i
csr_adr_read_o  out  12  to CSR file adr_read_i
csr_rdata_i  in  XLEN  from CSR file data_o

Behaviour:
- FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
- Reset: state IDLE; all outputs 0; internal trap latches cleared. Reset mid-sequence aborts it, with no further writes or redirect.
- Priority in IDLE: trap_v_i > mret_v_i > csr_req_v_i. A lower-priority request is not acked and must be held by its source.

IDLE, CSR instruction (single cycle, combinational):
- csr_adr_read_o=csr_adr_i; csr_rd_data_o=csr_rdata_i; csr_ack_o=1.
- Write value: RW gives wdata; RS gives rdata|wdata; RC gives rdata&~wdata.
- csr_write_v_o=1 except when op=00, or when op is RS/RC with csr_no_wr_i=1.

IDLE, trap:
- Latch cause/pc/tval; go to T_EPC. No write in the accept cycle.

Trap sequence (one write per state, each state lasts 1 cycle):
- T_EPC writes mepc = {pc[XLEN-1:2],2'b00}.
- T_CAUSE writes mcause.
- T_TVAL writes mtval.
- T_STATUS reads then writes mstatus: MPIE(7) <= MIE(3), MIE <= 0, MPP[12:11] <= 2'b11, other bits unchanged.
- T_JUMP reads mtvec, asserts redirect_v_o for 1 cycle, returns to IDLE. No write.
  - Target when mtvec[1:0]==01 and cause[XLEN-1]==1: {mtvec[XLEN-1:2],2'b00} + (cause[XLEN-2:0]<<2).
  - Otherwise: {mtvec[XLEN-1:2],2'b00}.
  - Arithmetic is modulo 2^XLEN.
- Redirect appears 5 cycles after the accept cycle.

MRET sequence:
- R_STATUS reads then writes mstatus: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- R_JUMP reads mepc; redirect_pc_o = mepc & ~3; redirect_v_o=1; back to IDLE.

Handshake and output rules:
- busy_o=1 in every non-IDLE state. trap_v_i, mret_v_i and csr_req_v_i are ignored while busy.
- The accept cycle of a trap or MRET acks no CSR instruction.
- csr_write_v_o is 0 in IDLE with no write, in T_JUMP and in R_JUMP.
- csr_adr_write_o, csr_wdata_o and redirect_pc_o are 0 whenever their valid is low.
- csr_adr_read_o is 0 when unused.
- Trap and MRET in the same IDLE cycle: trap wins, MRET is dropped. The pipeline flushes it via redirect.

Decomposition:
- Shared package (existing CSR package): CSR address constants; csr_op_e enum; state enum; mstatus bit-index constants (MIE=3, MPIE=7, MPP=12:11).
- Sub-module csr_rmw_alu: combinational RW/RS/RC/no-write computation, reused for CSR instructions.
- mstatus field updates stay inline.

Test Plan:
- Reset mid-T_TVAL: assert reset during T_TVAL -> IDLE; mtval and mstatus unwritten; no redirect_v_o.
- CSRRW 0x340 with wdata 0xDEADBEEF, old value 0 -> same cycle: ack=1, write_v=1, adr_write=0x340, wdata=0xDEADBEEF, rd_data=0.
- CSRRS on mstatus=0x8 with wdata 0x80, then CSRRC with csr_no_wr_i=1 -> first writes 0x88; second has ack=1, write_v=0, rd_data=0x88.
- Trap with mstatus=0x8, mtvec=0x1000, cause=2, pc=0x206, tval=0x13 -> in order: mepc=0x204, mcause=2, mtval=0x13, mstatus=0x1880; cycle 5 redirect to 0x1000; busy_o high for 5 cycles.
- Trap with mtvec=0x1001, cause=0x80000007 -> redirect_pc_o=0x101C.
- Trap, MRET and CSR request in the same cycle -> trap sequence runs; no ack; MRET dropped. Then MRET with mepc=0x204, mstatus=0x1880 -> mstatus=0x1888; redirect to 0x204 two cycles after accept.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// rtl/csr_trap_ctrl_pkg.sv - shared CSR addresses, op codes, FSM states and mstatus fields
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_T_EPC    = 3'd1;
  localparam logic [2:0] ST_T_CAUSE  = 3'd2;
  localparam logic [2:0] ST_T_TVAL   = 3'd3;
  localparam logic [2:0] ST_T_STATUS = 3'd4;
  localparam logic [2:0] ST_T_JUMP   = 3'd5;
  localparam logic [2:0] ST_R_STATUS = 3'd6;
  localparam logic [2:0] ST_R_JUMP   = 3'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_rmw_alu.sv
// rtl/csr_rmw_alu.sv - read-modify-write value and write enable for CSR instructions
module csr_rmw_alu
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e           op_i,
  input  logic [XLEN-1:0]   rdata_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              no_wr_i,
  output logic              we_o,
  output logic [XLEN-1:0]   result_o
);

  // RS/RC with a zero source operand must not write (side-effect free read)
  always_comb begin
    we_o     = 1'b0;
    result_o = rdata_i;
    case (op_i)
      CSR_OP_RW: begin
        we_o     = 1'b1;
        result_o = wdata_i;
      end
      CSR_OP_RS: begin
        we_o     = ~no_wr_i;
        result_o = rdata_i | wdata_i;
      end
      CSR_OP_RC: begin
        we_o     = ~no_wr_i;
        result_o = rdata_i & ~wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - sequences CSR instruction, trap entry and MRET writes into the CSR file
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_req_v_i,
  input  logic [1:0]        csr_op_i,
  input  logic [11:0]       csr_adr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              csr_no_wr_i,
  output logic              csr_ack_o,
  output logic [XLEN-1:0]   csr_rd_data_o,
  input  logic              trap_v_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_tval_i,
  input  logic              mret_v_i,
  output logic              busy_o,
  output logic              redirect_v_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              csr_write_v_o,
  output logic [11:0]       csr_adr_write_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic [11:0]       csr_adr_read_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] cause_q, pc_q, tval_q;
  logic            alu_we;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mstat;
  logic [XLEN-1:0] tvec_base;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .op_i     (csr_op_e'(csr_op_i)),
    .rdata_i  (csr_rdata_i),
    .wdata_i  (csr_wdata_i),
    .no_wr_i  (csr_no_wr_i),
    .we_o     (alu_we),
    .result_o (alu_res)
  );

  // State register and trap operand capture in the accept cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && trap_v_i) begin
        cause_q <= trap_cause_i;
        pc_q    <= trap_pc_i;
        tval_q  <= trap_tval_i;
      end
    end
  end

  // Next state and all CSR-file/redirect outputs; everything is forced low under reset
  always_comb begin
    state_d         = state_q;
    csr_ack_o       = 1'b0;
    csr_rd_data_o   = '0;
    busy_o          = (state_q != ST_IDLE);
    redirect_v_o    = 1'b0;
    redirect_pc_o   = '0;
    csr_write_v_o   = 1'b0;
    csr_adr_write_o = '0;
    csr_wdata_o     = '0;
    csr_adr_read_o  = '0;
    mstat           = csr_rdata_i;
    tvec_base       = csr_rdata_i & ALIGN_MASK;

    case (state_q)
      ST_IDLE: begin
        if (trap_v_i) begin
          state_d = ST_T_EPC;
        end else if (mret_v_i) begin
          state_d = ST_R_STATUS;
        end else if (csr_req_v_i) begin
          csr_ack_o      = 1'b1;
          csr_adr_read_o = csr_adr_i;
          csr_rd_data_o  = csr_rdata_i;
          if (alu_we) begin
            csr_write_v_o   = 1'b1;
            csr_adr_write_o = csr_adr_i;
            csr_wdata_o     = alu_res;
          end
        end
      end
      ST_T_EPC: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MEPC;
        csr_wdata_o     = pc_q & ALIGN_MASK;
        state_d         = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MCAUSE;
        csr_wdata_o     = cause_q;
        state_d         = ST_T_TVAL;
      end
      ST_T_TVAL: begin
        csr_write_v_o   = 1'b1;
        csr_adr_write_o = CSR_MTVAL;
        csr_wdata_o     = tval_q;
        state_d         = ST_T_STATUS;
      end
      ST_T_STATUS: begin
        csr_adr_read_o                        = CSR_MSTATUS;
        mstat[MSTATUS_MPIE]                   = csr_rdata_i[MSTATUS_MIE];
        mstat[MSTATUS_MIE]                    = 1'b0;
        mstat[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        csr_write_v_o                         = 1'b1;
        csr_adr_write_o                       = CSR_MSTATUS;
        csr_wdata_o                           = mstat;
        state_d                               = ST_T_JUMP;
      end
      ST_T_JUMP: begin
        csr_adr_read_o = CSR_MTVEC;
        redirect_v_o   = 1'b1;
        // Vectored mode only applies to interrupts; exceptions always go to the base
        if (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1])
          redirect_pc_o = tvec_base + {cause_q[XLEN-3:0], 2'b00};
        else
          redirect_pc_o = tvec_base;
        state_d = ST_IDLE;
      end
      ST_R_STATUS: begin
        csr_adr_read_o                        = CSR_MSTATUS;
        mstat[MSTATUS_MIE]                    = csr_rdata_i[MSTATUS_MPIE];
        mstat[MSTATUS_MPIE]                   = 1'b1;
        mstat[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        csr_write_v_o                         = 1'b1;
        csr_adr_write_o                       = CSR_MSTATUS;
        csr_wdata_o                           = mstat;
        state_d                               = ST_R_JUMP;
      end
      ST_R_JUMP: begin
        csr_adr_read_o = CSR_MEPC;
        redirect_v_o   = 1'b1;
        redirect_pc_o  = csr_rdata_i & ALIGN_MASK;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset) begin
      csr_ack_o       = 1'b0;
      csr_rd_data_o   = '0;
      busy_o          = 1'b0;
      redirect_v_o    = 1'b0;
      redirect_pc_o   = '0;
      csr_write_v_o   = 1'b0;
      csr_adr_write_o = '0;
      csr_wdata_o     = '0;
      csr_adr_read_o  = '0;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - randomized and directed bench for csr_trap_ctrl against a transaction-level model
module tb_csr_trap_ctrl;

  localparam int XLEN = 32;

  logic              clk;
  logic              reset;
  logic              csr_req_v_i;
  logic [1:0]        csr_op_i;
  logic [11:0]       csr_adr_i;
  logic [XLEN-1:0]   csr_wdata_i;
  logic              csr_no_wr_i;
  logic              csr_ack_o;
  logic [XLEN-1:0]   csr_rd_data_o;
  logic              trap_v_i;
  logic [XLEN-1:0]   trap_cause_i;
  logic [XLEN-1:0]   trap_pc_i;
  logic [XLEN-1:0]   trap_tval_i;
  logic              mret_v_i;
  logic              busy_o;
  logic              redirect_v_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic              csr_write_v_o;
  logic [11:0]       csr_adr_write_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic [11:0]       csr_adr_read_o;
  logic [XLEN-1:0]   csr_rdata_i;

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wv;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  csr_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .csr_req_v_i     (csr_req_v_i),
    .csr_op_i        (csr_op_i),
    .csr_adr_i       (csr_adr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_no_wr_i     (csr_no_wr_i),
    .csr_ack_o       (csr_ack_o),
    .csr_rd_data_o   (csr_rd_data_o),
    .trap_v_i        (trap_v_i),
    .trap_cause_i    (trap_cause_i),
    .trap_pc_i       (trap_pc_i),
    .trap_tval_i     (trap_tval_i),
    .mret_v_i        (mret_v_i),
    .busy_o          (busy_o),
    .redirect_v_o    (redirect_v_o),
    .redirect_pc_o   (redirect_pc_o),
    .csr_write_v_o   (csr_write_v_o),
    .csr_adr_write_o (csr_adr_write_o),
    .csr_wdata_o     (csr_wdata_o),
    .csr_adr_read_o  (csr_adr_read_o),
    .csr_rdata_i     (csr_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_rdata_i = csr_mem[csr_adr_read_o];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic wv, input logic [11:0] wa, input logic [31:0] wd,
                              input logic [11:0] ra, input logic rv, input logic [31:0] rpc);
    exp_t e;
    e.wv = wv; e.wa = wa; e.wd = wd; e.ra = ra; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  // CSR file: write sampled before the edge, committed on the edge
  initial begin : csr_file
    logic        pw;
    logic [11:0] pa;
    logic [31:0] pd;
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      pw = csr_write_v_o; pa = csr_adr_write_o; pd = csr_wdata_o;
      @(posedge clk);
      if (pw) csr_mem[pa] = pd;
    end
  end

  // Transaction-level reference: each accepted trap/MRET expands into a list of expected cycles
  initial begin : model
    exp_t        q[$];
    exp_t        e;
    logic [31:0] old, nv, base, tgt, st;
    logic        we;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        chk("m_rst_busy", busy_o, 0);
        chk("m_rst_ack", csr_ack_o, 0);
        chk("m_rst_wv", csr_write_v_o, 0);
        chk("m_rst_wa", csr_adr_write_o, 0);
        chk("m_rst_wd", csr_wdata_o, 0);
        chk("m_rst_ra", csr_adr_read_o, 0);
        chk("m_rst_rd", csr_rd_data_o, 0);
        chk("m_rst_rv", redirect_v_o, 0);
        chk("m_rst_rpc", redirect_pc_o, 0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("m_seq_busy", busy_o, 1);
        chk("m_seq_ack", csr_ack_o, 0);
        chk("m_seq_wv", csr_write_v_o, e.wv);
        chk("m_seq_wa", csr_adr_write_o, e.wa);
        chk("m_seq_wd", csr_wdata_o, e.wd);
        chk("m_seq_ra", csr_adr_read_o, e.ra);
        chk("m_seq_rv", redirect_v_o, e.rv);
        chk("m_seq_rpc", redirect_pc_o, e.rpc);
        if (e.wv) ref_mem[e.wa] = e.wd;
      end else begin
        chk("m_idle_busy", busy_o, 0);
        chk("m_idle_rv", redirect_v_o, 0);
        chk("m_idle_rpc", redirect_pc_o, 0);
        if (trap_v_i || mret_v_i) begin
          chk("m_acc_ack", csr_ack_o, 0);
          chk("m_acc_wv", csr_write_v_o, 0);
          chk("m_acc_ra", csr_adr_read_o, 0);
          if (trap_v_i) begin
            st   = ref_mem[12'h300];
            st   = (st & ~32'h0000_1888) | 32'h0000_1800 | (st[3] ? 32'h80 : 32'h0);
            base = ref_mem[12'h305] & 32'hFFFF_FFFC;
            tgt  = base;
            if (ref_mem[12'h305][1:0] == 2'b01 && trap_cause_i[31])
              tgt = base + ((trap_cause_i & 32'h7FFF_FFFF) << 2);
            q.push_back(mk(1, 12'h341, trap_pc_i & 32'hFFFF_FFFC, 12'h0, 0, 0));
            q.push_back(mk(1, 12'h342, trap_cause_i, 12'h0, 0, 0));
            q.push_back(mk(1, 12'h343, trap_tval_i, 12'h0, 0, 0));
            q.push_back(mk(1, 12'h300, st, 12'h300, 0, 0));
            q.push_back(mk(0, 12'h0, 0, 12'h305, 1, tgt));
          end else begin
            st = ref_mem[12'h300];
            st = (st & ~32'h0000_1888) | 32'h0000_1880 | (st[7] ? 32'h8 : 32'h0);
            q.push_back(mk(1, 12'h300, st, 12'h300, 0, 0));
            q.push_back(mk(0, 12'h0, 0, 12'h341, 1, ref_mem[12'h341] & 32'hFFFF_FFFC));
          end
        end else if (csr_req_v_i) begin
          old = ref_mem[csr_adr_i];
          case (csr_op_i)
            2'b01:   nv = csr_wdata_i;
            2'b10:   nv = old | csr_wdata_i;
            2'b11:   nv = old & ~csr_wdata_i;
            default: nv = old;
          endcase
          we = (csr_op_i == 2'b01) || (csr_op_i != 2'b00 && !csr_no_wr_i);
          chk("m_csr_ack", csr_ack_o, 1);
          chk("m_csr_rd", csr_rd_data_o, old);
          chk("m_csr_ra", csr_adr_read_o, csr_adr_i);
          chk("m_csr_wv", csr_write_v_o, we);
          chk("m_csr_wa", csr_adr_write_o, we ? csr_adr_i : 12'h0);
          chk("m_csr_wd", csr_wdata_o, we ? nv : 32'h0);
          if (we) ref_mem[csr_adr_i] = nv;
        end else begin
          chk("m_nop_ack", csr_ack_o, 0);
          chk("m_nop_wv", csr_write_v_o, 0);
          chk("m_nop_wa", csr_adr_write_o, 0);
          chk("m_nop_wd", csr_wdata_o, 0);
          chk("m_nop_ra", csr_adr_read_o, 0);
        end
      end
    end
  end

  task automatic set_idle();
    csr_req_v_i = 0; csr_op_i = 2'b00; csr_adr_i = 12'h0; csr_wdata_i = 0; csr_no_wr_i = 0;
    trap_v_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0; mret_v_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_csr(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] wd, input logic nw);
    cyc();
    set_idle();
    csr_req_v_i = 1; csr_op_i = op; csr_adr_i = adr; csr_wdata_i = wd; csr_no_wr_i = nw;
    @(negedge clk);
  endtask

  task automatic start_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    cyc();
    set_idle();
    trap_v_i = 1; trap_cause_i = cause; trap_pc_i = pc; trap_tval_i = tval;
    @(negedge clk);
    chk("t_acc_busy", busy_o, 0);
    chk("t_acc_wv", csr_write_v_o, 0);
  endtask

  task automatic trap_seq(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] tval,
                          input logic [31:0] mst, input logic [31:0] tgt);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      set_idle();
      @(negedge clk);
      chk("t_busy", busy_o, 1);
      case (k)
        1: begin chk("t_epc_wa", csr_adr_write_o, 12'h341); chk("t_epc_wd", csr_wdata_o, epc); end
        2: begin chk("t_cause_wa", csr_adr_write_o, 12'h342); chk("t_cause_wd", csr_wdata_o, cause); end
        3: begin chk("t_tval_wa", csr_adr_write_o, 12'h343); chk("t_tval_wd", csr_wdata_o, tval); end
        4: begin chk("t_stat_wa", csr_adr_write_o, 12'h300); chk("t_stat_wd", csr_wdata_o, mst); end
        default: begin
          chk("t_jump_wv", csr_write_v_o, 0);
          chk("t_jump_rv", redirect_v_o, 1);
          chk("t_jump_pc", redirect_pc_o, tgt);
        end
      endcase
      if (k < 5) begin
        chk("t_wv", csr_write_v_o, 1);
        chk("t_no_rv", redirect_v_o, 0);
      end
    end
    cyc();
    @(negedge clk);
    chk("t_done_busy", busy_o, 0);
    chk("t_done_rv", redirect_v_o, 0);
  endtask

  logic [11:0] adrs [6];

  initial begin : stim
    adrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
    reset = 1;
    set_idle();
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_redirect", redirect_v_o, 0);
    chk("rst_wv", csr_write_v_o, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // CSRRW to mscratch
    do_csr(2'b01, 12'h340, 32'hDEADBEEF, 0);
    chk("rw_ack", csr_ack_o, 1);
    chk("rw_wv", csr_write_v_o, 1);
    chk("rw_wa", csr_adr_write_o, 12'h340);
    chk("rw_wd", csr_wdata_o, 32'hDEADBEEF);
    chk("rw_rd", csr_rd_data_o, 32'h0);

    // CSRRS then CSRRC with no write
    do_csr(2'b01, 12'h300, 32'h8, 0);
    do_csr(2'b10, 12'h300, 32'h80, 0);
    chk("rs_wv", csr_write_v_o, 1);
    chk("rs_wd", csr_wdata_o, 32'h88);
    do_csr(2'b11, 12'h300, 32'hFF, 1);
    chk("rc_ack", csr_ack_o, 1);
    chk("rc_wv", csr_write_v_o, 0);
    chk("rc_rd", csr_rd_data_o, 32'h88);

    // Exception trap, direct mode
    do_csr(2'b01, 12'h300, 32'h8, 0);
    do_csr(2'b01, 12'h305, 32'h1000, 0);
    start_trap(32'h2, 32'h206, 32'h13);
    trap_seq(32'h204, 32'h2, 32'h13, 32'h1880, 32'h1000);

    // Interrupt trap, vectored mode
    do_csr(2'b01, 12'h300, 32'h8, 0);
    do_csr(2'b01, 12'h305, 32'h1001, 0);
    start_trap(32'h8000_0007, 32'h100, 32'h0);
    trap_seq(32'h100, 32'h8000_0007, 32'h0, 32'h1880, 32'h101C);

    // Trap, MRET and CSR in one cycle; then a real MRET
    do_csr(2'b01, 12'h300, 32'h8, 0);
    do_csr(2'b01, 12'h305, 32'h1000, 0);
    cyc();
    set_idle();
    trap_v_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h206; trap_tval_i = 32'h13;
    mret_v_i = 1; csr_req_v_i = 1; csr_op_i = 2'b01; csr_adr_i = 12'h340; csr_wdata_i = 32'h55;
    @(negedge clk);
    chk("tie_ack", csr_ack_o, 0);
    chk("tie_wv", csr_write_v_o, 0);
    trap_seq(32'h204, 32'h2, 32'h13, 32'h1880, 32'h1000);
    chk("tie_mscratch", csr_mem[12'h340], 32'hDEADBEEF);
    cyc();
    set_idle();
    mret_v_i = 1;
    @(negedge clk);
    chk("mret_acc_busy", busy_o, 0);
    chk("mret_acc_ack", csr_ack_o, 0);
    cyc();
    set_idle();
    @(negedge clk);
    chk("mret_st_wv", csr_write_v_o, 1);
    chk("mret_st_wa", csr_adr_write_o, 12'h300);
    chk("mret_st_wd", csr_wdata_o, 32'h1888);
    chk("mret_st_rv", redirect_v_o, 0);
    cyc();
    @(negedge clk);
    chk("mret_rv", redirect_v_o, 1);
    chk("mret_pc", redirect_pc_o, 32'h204);
    chk("mret_jump_wv", csr_write_v_o, 0);
    cyc();
    @(negedge clk);
    chk("mret_done_busy", busy_o, 0);

    // Reset in the middle of T_TVAL
    do_csr(2'b01, 12'h343, 32'h77, 0);
    do_csr(2'b01, 12'h300, 32'h8, 0);
    start_trap(32'h5, 32'h300, 32'h99);
    cyc(); set_idle(); @(negedge clk);
    cyc(); @(negedge clk);
    cyc();
    reset = 1;
    @(negedge clk);
    chk("rst_tval_wv", csr_write_v_o, 0);
    chk("rst_tval_busy", busy_o, 0);
    cyc();
    cyc();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_after_rv", redirect_v_o, 0);
      chk("rst_after_busy", busy_o, 0);
      cyc();
    end
    chk("rst_mtval", csr_mem[12'h343], 32'h77);
    chk("rst_mstatus", csr_mem[12'h300], 32'h8);
    chk("rst_mcause", csr_mem[12'h342], 32'h5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      reset = ($urandom_range(0, 299) == 0);
      trap_v_i     = ($urandom_range(0, 15) == 0);
      mret_v_i     = ($urandom_range(0, 11) == 0);
      csr_req_v_i  = ($urandom_range(0, 1) == 0);
      csr_op_i     = 2'($urandom_range(0, 3));
      csr_adr_i    = adrs[$urandom_range(0, 5)];
      csr_wdata_i  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      csr_no_wr_i  = ($urandom_range(0, 2) == 0);
      trap_cause_i = $urandom;
      if ($urandom_range(0, 1) == 0) trap_cause_i[30:0] = 31'($urandom_range(0, 15));
      trap_pc_i    = $urandom;
      trap_tval_i  = $urandom;
      cyc();
    end
    reset = 0;
    set_idle();
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
